p4s1_fft: RTL

- 4:1 parallel-to-serial converter for the FFT-1024 datapath; the transmit-side counterpart of the 4-word serial-to-parallel stage.
- Accepts one 4-word parallel group and emits it as 4 serial words, one per enabled cycle.
- Word order is chosen so that a round trip through the serial-to-parallel stage reproduces the original stream order.
- Provides ready/valid status, a phase index and a sticky overrun flag.

---
 rtl/p4s1_fft_if.sv | 27 ++
 rtl/p4s1_fft.sv | 88 ++++++++
 2 files changed

// File: rtl/p4s1_fft_if.sv
// Bus bundle for the 4:1 parallel-to-serial stage: group load side plus serial output side.
interface p4s1_fft_if #(
  parameter int WORDLENGTH = 16
);
  logic                  enable;
  logic                  load;
  logic                  clr_ovf;
  logic [WORDLENGTH-1:0] data_in0;
  logic [WORDLENGTH-1:0] data_in1;
  logic [WORDLENGTH-1:0] data_in2;
  logic [WORDLENGTH-1:0] data_in3;
  logic [WORDLENGTH-1:0] data_out;
  logic                  valid_out;
  logic [1:0]            phase;
  logic                  ready;
  logic                  overrun;

  modport master (
    output enable, load, clr_ovf, data_in0, data_in1, data_in2, data_in3,
    input  data_out, valid_out, phase, ready, overrun
  );

  modport slave (
    input  enable, load, clr_ovf, data_in0, data_in1, data_in2, data_in3,
    output data_out, valid_out, phase, ready, overrun
  );
endinterface

// File: rtl/p4s1_fft.sv
// 4:1 parallel-to-serial converter for the FFT-1024 datapath; emits data_in3 first, data_in0 last.
module p4s1_fft #(
  parameter int WORDLENGTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  p4s1_fft_if.slave     bus,
  output logic          state_o
);

  // Handshake: a group is taken when enable && load && ready on a rising edge;
  // ready (= !active) is combinational, and a load while !ready is dropped and
  // sets the sticky overrun flag. valid_out marks a fresh word on data_out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_q;
  logic [1:0]            cnt_q;
  logic [WORDLENGTH-1:0] buf0_q;
  logic [WORDLENGTH-1:0] buf1_q;
  logic [WORDLENGTH-1:0] buf2_q;
  logic [WORDLENGTH-1:0] data_out_q;
  logic [1:0]            phase_q;
  logic                  valid_q;
  logic                  ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      buf2_q     <= '0;
      data_out_q <= '0;
      phase_q    <= 2'd0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (bus.enable) begin
      // A fresh overrun on the same edge as a clear wins.
      if (bus.load && state_q == SHIFT) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (bus.load) begin
            data_out_q <= bus.data_in3;
            phase_q    <= 2'd0;
            valid_q    <= 1'b1;
            buf0_q     <= bus.data_in0;
            buf1_q     <= bus.data_in1;
            buf2_q     <= bus.data_in2;
            cnt_q      <= 2'd1;
            state_q    <= SHIFT;
          end else begin
            valid_q <= 1'b0;
          end
        end
        SHIFT: begin
          case (cnt_q)
            2'd1:    data_out_q <= buf2_q;
            2'd2:    data_out_q <= buf1_q;
            default: data_out_q <= buf0_q;
          endcase
          phase_q <= cnt_q;
          valid_q <= 1'b1;
          cnt_q   <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.phase     = phase_q;
  assign bus.valid_out = valid_q;
  assign bus.overrun   = ovf_q;
  assign bus.ready     = (state_q == IDLE);
  assign state_o       = state_q;

endmodule
